vram_rect_fill: RTL

//  Memory-mapped rectangle-fill engine between MIO_BUS and VRAM_B port A.
//  CPU programs origin/size/colour, then issues a start; the engine writes one
//  8-bit pixel per clock into VRAM. vga_controller later scans the result out.

---
 rtl/vram_rect_fill.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/vram_rect_fill.sv
// rtl/vram_rect_fill.sv - rectangle-fill engine driving VRAM port A, CPU writes muxed in with priority
module vram_rect_fill #(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_we,
  input  logic [1:0]        cmd_sel,
  input  logic [31:0]       cmd_data,
  input  logic              cpu_vram_we,
  input  logic [ADDR_W-1:0] cpu_vram_addr,
  input  logic [DATA_W-1:0] cpu_vram_data,
  output logic              data_vram_we,
  output logic [ADDR_W-1:0] vram_waddr,
  output logic [DATA_W-1:0] vram_data_in,
  output logic              busy,
  output logic              done_pulse,
  output logic [31:0]       status_out
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_FILL, S_DONE} state_t;

  state_t              state_q;
  logic [7:0]          x0_q, y0_q, w_q, h_q;
  logic [DATA_W-1:0]   color_q;
  logic [7:0]          xoff_q, xlast_q, row_q, ylast_q;
  logic [ADDR_W-1:0]   row_base_q;
  logic                busy_q, done_pulse_q, done_sticky_q, aborted_q;

  // Command decode; abort outranks start when both bits are set.
  logic ctrl_wr, abort_cmd, start_cmd;
  assign ctrl_wr   = cmd_we && (cmd_sel == 2'd3);
  assign abort_cmd = ctrl_wr && cmd_data[1];
  assign start_cmd = ctrl_wr && cmd_data[0] && !cmd_data[1];

  // Only the low 16 bits of the command word carry fields.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^cmd_data[31:16];

  // Clipped rectangle bounds, evaluated while in INIT (registers are frozen while busy).
  logic [8:0]        x_end, y_end, x1, y1;
  logic              empty_rect;
  logic [ADDR_W-1:0] row_start;

  assign x_end = {1'b0, x0_q} + {1'b0, w_q};
  assign y_end = {1'b0, y0_q} + {1'b0, h_q};
  assign x1    = (x_end > 9'(H_RES)) ? 9'(H_RES) : x_end;
  assign y1    = (y_end > 9'(V_RES)) ? 9'(V_RES) : y_end;
  assign empty_rect = (w_q == 8'd0) || (h_q == 8'd0) ||
                      ({1'b0, x0_q} >= 9'(H_RES)) || ({1'b0, y0_q} >= 9'(V_RES));
  // y0*160 built as y0*128 + y0*32 so no multiplier is needed.
  assign row_start = (ADDR_W'(y0_q) << 7) + (ADDR_W'(y0_q) << 5) + ADDR_W'(x0_q);

  // Engine owns port A only in FILL, and never in the cycle an abort arrives.
  logic eng_we;
  assign eng_we = (state_q == S_FILL) && !abort_cmd;

  // Port A mux: a CPU write always wins, otherwise the engine pixel, otherwise idle zeros.
  always_comb begin
    data_vram_we = 1'b0;
    vram_waddr   = '0;
    vram_data_in = '0;
    if (cpu_vram_we) begin
      data_vram_we = 1'b1;
      vram_waddr   = cpu_vram_addr;
      vram_data_in = cpu_vram_data;
    end else if (eng_we) begin
      data_vram_we = 1'b1;
      vram_waddr   = row_base_q + ADDR_W'(xoff_q);
      vram_data_in = color_q;
    end
  end

  assign busy       = busy_q;
  assign done_pulse = done_pulse_q;
  assign status_out = {29'b0, aborted_q, done_sticky_q, busy_q};

  // Register file, fill FSM, pixel counters and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      x0_q          <= '0;
      y0_q          <= '0;
      w_q           <= '0;
      h_q           <= '0;
      color_q       <= '0;
      xoff_q        <= '0;
      xlast_q       <= '0;
      row_q         <= '0;
      ylast_q       <= '0;
      row_base_q    <= '0;
      busy_q        <= 1'b0;
      done_pulse_q  <= 1'b0;
      done_sticky_q <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      done_pulse_q <= 1'b0;

      if (cmd_we && !busy_q) begin
        case (cmd_sel)
          2'd0: begin x0_q <= cmd_data[7:0]; y0_q <= cmd_data[15:8]; end
          2'd1: begin w_q  <= cmd_data[7:0]; h_q  <= cmd_data[15:8]; end
          2'd2: color_q <= cmd_data[DATA_W-1:0];
          default: ;
        endcase
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_cmd) begin
            state_q       <= S_INIT;
            busy_q        <= 1'b1;
            done_sticky_q <= 1'b0;
            aborted_q     <= 1'b0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_INIT: begin
          if (abort_cmd) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
          end else if (empty_rect) begin
            state_q       <= S_DONE;
            busy_q        <= 1'b0;
            done_pulse_q  <= 1'b1;
            done_sticky_q <= 1'b1;
          end else begin
            state_q    <= S_FILL;
            row_base_q <= row_start;
            xoff_q     <= '0;
            xlast_q    <= 8'(x1 - {1'b0, x0_q} - 9'd1);
            row_q      <= y0_q;
            ylast_q    <= 8'(y1 - 9'd1);
          end
        end
        S_FILL: begin
          if (abort_cmd) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
          end else if (!cpu_vram_we) begin
            if (xoff_q == xlast_q) begin
              if (row_q == ylast_q) begin
                state_q       <= S_DONE;
                busy_q        <= 1'b0;
                done_pulse_q  <= 1'b1;
                done_sticky_q <= 1'b1;
              end else begin
                xoff_q     <= '0;
                row_base_q <= row_base_q + ADDR_W'(H_RES);
                row_q      <= row_q + 8'd1;
              end
            end else begin
              xoff_q <= xoff_q + 8'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
